// File: rtl/divide_ctrl_pkg.sv
// divide_ctrl_pkg
// Shared types and helpers for the runtime clock-divide controller.
//   state_e  : controller state, 2-bit encoding
//   max_div  : largest divisor representable on a counter of a given width
package divide_ctrl_pkg;

  // OFF holds the counter at zero. RUN counts. PEND counts while a new
  // divisor waits for the boundary. DRAIN counts out the current period,
  // then stops.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;

  // Largest legal divisor for a counter that is `width` bits wide.
  function automatic int unsigned max_div(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/divide_cnt.sv
// divide_cnt
// Modulo-N counter with a synchronous clear. It also registers the tick and
// divided-clock compares.
//   clk, rst_n : system clock, asynchronous active-low reset
//   run_i      : controller is in a counting state this cycle
//   clear_i    : controller stops next cycle; force count and div_clk to 0
//   div_i      : divisor in effect this cycle (governs the wrap point)
//   nxt_div_i  : divisor in effect next cycle (governs the div_clk compare)
//   at_max_o   : count equals div_i-1 (period boundary when running)
//   tick_o     : registered one-cycle pulse, high while the count is 0
//   div_clk_o  : registered divided clock, low for div>>1 cycles, then high
module divide_cnt
  import divide_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic [WIDTH-1:0] nxt_div_i,
  output logic             at_max_o,
  output logic             tick_o,
  output logic             div_clk_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             div_clk_q, div_clk_d;

  // The divisor is never zero, so div_i-1 cannot underflow. The wrap at
  // at_max keeps the increment from ever overflowing, even at 2**WIDTH-1.
  assign at_max_o = (cnt_q == (div_i - 1'b1));

  // Next count and the two compares. The tick is the registered boundary,
  // so it is high in the same cycle that the count shows 0. div_clk looks
  // at the next count against the next divisor. This way a divisor change
  // at the boundary shapes the first cycle of the new period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || clear_i || at_max_o) begin
      cnt_d = '0;
    end
    tick_d    = run_i && at_max_o;
    div_clk_d = !clear_i && (cnt_d >= (nxt_div_i >> 1));
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign div_clk_o = div_clk_q;

endmodule

// File: rtl/divide_ctrl.sv
// divide_ctrl
// Runtime controller for integer clock division. It owns the modulo counter
// through divide_cnt. It sequences divisor changes so that they land only on
// a period boundary, and it drains the current period before stopping.
//   clk, rst_n : system clock (posedge), asynchronous active-low reset
//   en         : 1 = run, 0 = stop at the next period boundary
//   cfg_valid  : new divisor request
//   cfg_div    : requested divisor
//   cfg_ready  : request accepted when cfg_valid & cfg_ready
//   cfg_err    : one-cycle pulse when a zero divisor request is dropped
//   upd_done   : one-cycle pulse when a new divisor has been applied
//   cur_div    : divisor currently in effect
//   tick       : one-cycle pulse at the start of each divided period
//   div_clk    : registered divided clock
//   busy       : controller is not OFF
module divide_ctrl
  import divide_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             upd_done,
  output logic [WIDTH-1:0] cur_div,
  output logic             tick,
  output logic             div_clk,
  output logic             busy
);

  localparam int unsigned      MAX_DIV = max_div(WIDTH);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEF_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             cfg_ready_q;
  logic             cfg_err_q, cfg_err_d;
  logic             upd_done_q, upd_done_d;
  logic             busy_q;
  logic             cfg_req, cfg_legal, cfg_accept;
  logic             at_max, cnt_run, cnt_clear, drain_stop;

  // A request is only looked at while ready. A zero divisor is rejected
  // with an error pulse and changes nothing else.
  assign cfg_req    = cfg_valid && cfg_ready_q;
  assign cfg_legal  = (cfg_div != '0) && (32'(cfg_div) <= MAX_DIV);
  assign cfg_accept = cfg_req && cfg_legal;
  assign cfg_err_d  = cfg_req && !cfg_legal;

  // A drain that reaches its boundary with en still low stops now. A request
  // arriving in that same cycle is then applied like an OFF-state write.
  // It does not buy an extra period.
  assign drain_stop = (state_q == DRAIN) && at_max && !en;

  // Controller FSM. In RUN, a request accepted on a boundary cycle is not
  // applied on that boundary. State moves to PEND, and PEND applies only on
  // its own boundary, so the new divisor always follows one full period
  // under the old one.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    upd_done_d = 1'b0;
    case (state_q)
      OFF: begin
        if (cfg_accept) begin
          cur_div_d  = cfg_div;
          upd_done_d = 1'b1;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_accept) begin
          pend_div_d = cfg_div;
          state_d    = PEND;
        end else if (!en) begin
          state_d = DRAIN;
        end
      end
      PEND: begin
        if (at_max) begin
          cur_div_d  = pend_div_q;
          upd_done_d = 1'b1;
          state_d    = en ? RUN : OFF;
        end
      end
      DRAIN: begin
        if (drain_stop) begin
          state_d = OFF;
          if (cfg_accept) begin
            cur_div_d  = cfg_div;
            upd_done_d = 1'b1;
          end
        end else if (cfg_accept) begin
          pend_div_d = cfg_div;
          state_d    = PEND;
        end else if (en) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  assign cnt_run   = (state_q != OFF);
  assign cnt_clear = (state_d == OFF);

  divide_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (cnt_run),
    .clear_i   (cnt_clear),
    .div_i     (cur_div_q),
    .nxt_div_i (cur_div_d),
    .at_max_o  (at_max),
    .tick_o    (tick),
    .div_clk_o (div_clk)
  );

  // Control registers. cfg_ready and busy are registered decodes of the
  // next state, so they track the state register with no input paths.
  // Reset drops any pending divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      cur_div_q   <= RST_DIV;
      pend_div_q  <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      upd_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      cfg_ready_q <= (state_d != PEND);
      cfg_err_q   <= cfg_err_d;
      upd_done_q  <= upd_done_d;
      busy_q      <= (state_d != OFF);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign upd_done  = upd_done_q;
  assign cur_div   = cur_div_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_divide_ctrl.sv
// tb_divide_ctrl
// Self-checking bench for divide_ctrl (WIDTH=8, DEF_DIV=3). Expected tick
// cycles are queued when the stimulus that causes them is driven. A negedge
// monitor pops the queue and compares it against every observed tick.
module tb_divide_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEF_DIV = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             upd_done;
  logic [WIDTH-1:0] cur_div;
  logic             tick;
  logic             div_clk;
  logic             busy;

  int unsigned cycleCnt = 0;
  int unsigned tickQ[$];
  int          compareCnt = 0;
  int          mismatchCnt = 0;

  divide_ctrl #(
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .upd_done  (upd_done),
    .cur_div   (cur_div),
    .tick      (tick),
    .div_clk   (div_clk),
    .busy      (busy)
  );

  // Free-running clock and a cycle index that the main flow reads just after
  // each rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
               tag, observed, expected, cycleCnt);
    end
  endtask

  // Drive inputs for the current cycle, then step to just after the next
  // rising edge.
  task automatic applyStimulus(input logic enV, input logic validV,
                               input logic [WIDTH-1:0] divV);
    en        = enV;
    cfg_valid = validV;
    cfg_div   = divV;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input logic enV);
    repeat (n) applyStimulus(enV, 1'b0, '0);
  endtask

  task automatic checkResetValues();
    checkOutput("rstCurDiv",   32'(cur_div),   32'(DEF_DIV));
    checkOutput("rstTick",     32'(tick),      32'd0);
    checkOutput("rstDivClk",   32'(div_clk),   32'd0);
    checkOutput("rstBusy",     32'(busy),      32'd0);
    checkOutput("rstCfgReady", 32'(cfg_ready), 32'd1);
    checkOutput("rstCfgErr",   32'(cfg_err),   32'd0);
    checkOutput("rstUpdDone",  32'(upd_done),  32'd0);
  endtask

  // Tick scoreboard. Every tick must match the head of the queue. Reaching
  // a queued cycle without a tick is also reported.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tick === 1'b1) begin
        if (tickQ.size() == 0) begin
          checkOutput("tickUnexpected", 32'(tick), 32'd0);
        end else begin
          checkOutput("tickCycle", cycleCnt, tickQ.pop_front());
        end
      end else if (tickQ.size() != 0 && tickQ[0] <= cycleCnt) begin
        void'(tickQ.pop_front());
        checkOutput("tickMissing", 32'(tick), 32'd1);
      end
    end
  end

  initial begin
    int unsigned t0, a, b, c, e;
    int lowCnt, highCnt, firstHigh;

    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;
    runCycles(1, 1'b0);

    // Start-up at the reset divisor 3: ticks at +4, +7, +10, div_clk 0,1,1.
    // en drops on the +10 tick, so the final drained tick lands at +13.
    t0 = cycleCnt;
    tickQ.push_back(t0 + 4);
    tickQ.push_back(t0 + 7);
    tickQ.push_back(t0 + 10);
    tickQ.push_back(t0 + 13);
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 1; i <= 9; i++) begin
      checkOutput("p1DivClk", 32'(div_clk), 32'(((i - 1) % 3) != 0));
      checkOutput("p1Busy",   32'(busy),    32'd1);
      applyStimulus(1'b1, 1'b0, '0);
    end
    runCycles(3, 1'b0);
    checkOutput("p1StopBusy",   32'(busy),    32'd0);
    checkOutput("p1StopDivClk", 32'(div_clk), 32'd0);
    runCycles(2, 1'b0);

    // Divisor write while OFF applies next cycle and stays OFF.
    a = cycleCnt;
    applyStimulus(1'b0, 1'b1, 8'd4);
    checkOutput("offUpdDone", 32'(upd_done), 32'd1);
    checkOutput("offCurDiv",  32'(cur_div),  32'd4);
    checkOutput("offBusy",    32'(busy),     32'd0);
    checkOutput("offElapsed", cycleCnt - a,  32'd1);

    // Run at 4, change to 6 mid-period, a zero write, a boundary-coincident
    // change to 5, then drain mid-period.
    b = cycleCnt;
    tickQ.push_back(b + 5);
    tickQ.push_back(b + 9);
    tickQ.push_back(b + 15);
    tickQ.push_back(b + 21);
    tickQ.push_back(b + 27);
    tickQ.push_back(b + 32);
    tickQ.push_back(b + 37);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("p2UpdDoneLow", 32'(upd_done), 32'd0);
    runCycles(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd6);
    checkOutput("p2PendReady",  32'(cfg_ready), 32'd0);
    checkOutput("p2PendCurDiv", 32'(cur_div),   32'd4);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("p2PendReady2", 32'(cfg_ready), 32'd0);
    checkOutput("p2PendUpd",    32'(upd_done),  32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("p2ApplyUpd",    32'(upd_done),  32'd1);
    checkOutput("p2ApplyCurDiv", 32'(cur_div),   32'd6);
    checkOutput("p2ApplyReady",  32'(cfg_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 8'd0);
    checkOutput("errPulse",  32'(cfg_err),   32'd1);
    checkOutput("errReady",  32'(cfg_ready), 32'd1);
    checkOutput("errCurDiv", 32'(cur_div),   32'd6);
    checkOutput("errBusy",   32'(busy),      32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("errPulseEnd", 32'(cfg_err), 32'd0);
    runCycles(8, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd5);
    checkOutput("bndReady",  32'(cfg_ready), 32'd0);
    checkOutput("bndCurDiv", 32'(cur_div),   32'd6);
    checkOutput("bndUpd",    32'(upd_done),  32'd0);
    runCycles(5, 1'b1);
    checkOutput("bndHoldCurDiv", 32'(cur_div), 32'd6);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("bndApplyCurDiv", 32'(cur_div),  32'd5);
    checkOutput("bndApplyUpd",    32'(upd_done), 32'd1);
    runCycles(6, 1'b1);
    checkOutput("n5DivClkLow",  32'(div_clk), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("n5DivClkHigh", 32'(div_clk), 32'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drainBusy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drainBusy2",  32'(busy),    32'd1);
    checkOutput("drainDivClk", 32'(div_clk), 32'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drainOffBusy",   32'(busy),    32'd0);
    checkOutput("drainOffDivClk", 32'(div_clk), 32'd0);
    runCycles(2, 1'b0);

    // Restart at 5 (first tick 5 after RUN entry), go to N=1, then to N=255.
    c = cycleCnt;
    tickQ.push_back(c + 6);
    tickQ.push_back(c + 7);
    tickQ.push_back(c + 8);
    tickQ.push_back(c + 9);
    tickQ.push_back(c + 10);
    tickQ.push_back(c + 265);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("restartBusy",   32'(busy),    32'd1);
    checkOutput("restartDivClk", 32'(div_clk), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 8'd1);
    checkOutput("n1PendReady", 32'(cfg_ready), 32'd0);
    runCycles(3, 1'b1);
    checkOutput("n1Upd",    32'(upd_done), 32'd1);
    checkOutput("n1CurDiv", 32'(cur_div),  32'd1);
    checkOutput("n1DivClk", 32'(div_clk),  32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("n1DivClk2", 32'(div_clk), 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("n1DivClk3", 32'(div_clk), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'd255);
    checkOutput("n255PendReady", 32'(cfg_ready), 32'd0);
    checkOutput("n255PendCur",   32'(cur_div),   32'd1);
    checkOutput("n1DivClk4",     32'(div_clk),   32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("n255CurDiv", 32'(cur_div),   32'd255);
    checkOutput("n255Upd",    32'(upd_done),  32'd1);
    checkOutput("n255Ready",  32'(cfg_ready), 32'd1);
    lowCnt    = 0;
    highCnt   = 0;
    firstHigh = -1;
    for (int i = 0; i < 255; i++) begin
      if (div_clk === 1'b1) begin
        highCnt++;
        if (firstHigh < 0) firstHigh = i;
      end else begin
        lowCnt++;
      end
      applyStimulus(1'b1, 1'b0, '0);
    end
    checkOutput("n255Low",       32'(lowCnt),    32'd127);
    checkOutput("n255High",      32'(highCnt),   32'd128);
    checkOutput("n255FirstHigh", 32'(firstHigh), 32'd127);

    // Reset while PEND: everything returns to reset values and the pending
    // divisor 9 never shows up.
    runCycles(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd9);
    checkOutput("rstPendReady", 32'(cfg_ready), 32'd0);
    runCycles(3, 1'b1);
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runCycles(3, 1'b0);
    checkOutput("postRstCurDiv", 32'(cur_div),  32'd3);
    checkOutput("postRstUpd",    32'(upd_done), 32'd0);
    e = cycleCnt;
    tickQ.push_back(e + 4);
    tickQ.push_back(e + 7);
    tickQ.push_back(e + 10);
    runCycles(5, 1'b1);
    checkOutput("postRstRunCur", 32'(cur_div),  32'd3);
    checkOutput("postRstRunUpd", 32'(upd_done), 32'd0);
    runCycles(2, 1'b1);
    runCycles(3, 1'b0);
    checkOutput("postRstStop", 32'(busy), 32'd0);
    runCycles(4, 1'b0);
    checkOutput("tickQueueEmpty", 32'(tickQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
